// File: rtl/miner_result_fifo.sv
// -----------------------------------------------------------------------------
// miner_result_fifo
//
// Purpose:
//   Buffers winning mining results (hash-counter snapshot, nonce, hash) that
//   arrive as single-cycle pulses from the miner top level. Up to DEPTH results
//   are held until software drains them one 32-bit word at a time. A level
//   interrupt stays high while anything is pending or a result was dropped.
//
// Entry layout (one row of storage):
//   word 0                      : HashCounter_I
//   words 1 .. NONCE_WORDS      : Nonce_I[0..NONCE_WORDS-1]
//   following HASH_WORDS words  : Hash_I[0..HASH_WORDS-1]
//   last word (optional)        : free-running cycle timestamp
//
// Optional feature macro:
//   MINER_RESULT_TIMESTAMP_EN - adds a 32-bit free-running cycle counter
//   (reset by Rst only) whose value in the push cycle is stored as an extra
//   trailing word, making each entry 16 words long.
//
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   Clear_I         flush FIFO, overflow flag and drop counter (new job)
//   VldNonce_I      one-cycle pulse, result inputs valid this cycle
//   Nonce_I         winning nonce words, word 0 least significant
//   Hash_I          winning hash words, word 0 least significant
//   HashCounter_I   running hash count snapshot
//   RdReq_I         consume the current read word
//   RdData_O        current read word (0 when empty)
//   RdVld_O         RdData_O is valid (FIFO not empty)
//   WordIdx_O       index of current word within its entry
//   Count_O         number of stored entries
//   Empty_O/Full_O  occupancy flags
//   Overflow_O      sticky, a result was dropped
//   DropCnt_O       dropped-result count, saturating at 255
//   Irq_O           level interrupt: pending data or overflow
// -----------------------------------------------------------------------------
module miner_result_fifo #(
    parameter int DEPTH       = 4,
    parameter int PTR_WIDTH   = 2,
    parameter int NONCE_WORDS = 6,
    parameter int HASH_WORDS  = 8
) (
    input  logic                              Clk,
    input  logic                              Rst,
    input  logic                              Clear_I,
    input  logic                              VldNonce_I,
    input  logic [NONCE_WORDS-1:0][31:0]      Nonce_I,
    input  logic [HASH_WORDS-1:0][31:0]       Hash_I,
    input  logic [31:0]                       HashCounter_I,
    input  logic                              RdReq_I,
    output logic [31:0]                       RdData_O,
    output logic                              RdVld_O,
    output logic [3:0]                        WordIdx_O,
    output logic [PTR_WIDTH:0]                Count_O,
    output logic                              Empty_O,
    output logic                              Full_O,
    output logic                              Overflow_O,
    output logic [7:0]                        DropCnt_O,
    output logic                              Irq_O
);

`ifdef MINER_RESULT_TIMESTAMP_EN
    localparam int ENTRY_WORDS = 1 + NONCE_WORDS + HASH_WORDS + 1;
`else
    localparam int ENTRY_WORDS = 1 + NONCE_WORDS + HASH_WORDS;
`endif
    localparam int NONCE_BASE = 1;
    localparam int HASH_BASE  = 1 + NONCE_WORDS;

    localparam logic [3:0]         LAST_WORD = 4'(ENTRY_WORDS - 1);
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH + 1)'(DEPTH);

    // Storage: one full entry per row, written in a single cycle.
    logic [ENTRY_WORDS-1:0][31:0] mem_reg [DEPTH];
    logic [ENTRY_WORDS-1:0][31:0] entry_next;
    logic [ENTRY_WORDS-1:0][31:0] rd_entry;

    logic [PTR_WIDTH-1:0] wr_ptr_reg;
    logic [PTR_WIDTH-1:0] rd_ptr_reg;
    logic [3:0]           word_idx_reg;
    logic [PTR_WIDTH:0]   count_reg;
    logic                 overflow_reg;
    logic [7:0]           drop_cnt_reg;

    logic empty;
    logic full;
    logic rd_fire;
    logic pop;
    logic push_ok;
    logic drop;

    // -------------------------------------------------------------------------
    // Entry assembly
    // -------------------------------------------------------------------------
    assign entry_next[0] = HashCounter_I;

    generate
        for (genvar gi = 0; gi < NONCE_WORDS; gi++) begin : g_nonce
            assign entry_next[NONCE_BASE + gi] = Nonce_I[gi];
        end
        for (genvar gi = 0; gi < HASH_WORDS; gi++) begin : g_hash
            assign entry_next[HASH_BASE + gi] = Hash_I[gi];
        end
    endgenerate

`ifdef MINER_RESULT_TIMESTAMP_EN
    // Free-running cycle counter; deliberately not cleared by Clear_I so
    // timestamps stay monotonic across mining jobs.
    logic [31:0] ts_reg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_reg + 32'd1;
        end
    end

    assign entry_next[ENTRY_WORDS-1] = ts_reg;
`endif

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    assign empty   = (count_reg == '0);
    assign full    = (count_reg == DEPTH_CNT);
    assign rd_fire = RdReq_I && !empty;
    assign pop     = rd_fire && (word_idx_reg == LAST_WORD);
    // A pop of the last word frees a slot, so a push in the same cycle is
    // accepted even when the FIFO is full.
    assign push_ok = VldNonce_I && !Clear_I && (!full || pop);
    assign drop    = VldNonce_I && !Clear_I && full && !pop;

    // -------------------------------------------------------------------------
    // Storage write (contents need no reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (push_ok && !Rst) begin
            mem_reg[wr_ptr_reg] <= entry_next;
        end
    end

    // -------------------------------------------------------------------------
    // Pointers, occupancy and drop accounting
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst || Clear_I) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            word_idx_reg <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else begin
            if (rd_fire) begin
                if (pop) begin
                    word_idx_reg <= '0;
                    rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                end else begin
                    word_idx_reg <= word_idx_reg + 4'd1;
                end
            end

            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            if (drop) begin
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read port and status
    // -------------------------------------------------------------------------
    assign rd_entry   = mem_reg[rd_ptr_reg];
    // Forced to zero when empty so stale storage never leaks to software.
    assign RdData_O   = empty ? 32'd0 : rd_entry[word_idx_reg];
    assign RdVld_O    = !empty;
    assign WordIdx_O  = word_idx_reg;
    assign Count_O    = count_reg;
    assign Empty_O    = empty;
    assign Full_O     = full;
    assign Overflow_O = overflow_reg;
    assign DropCnt_O  = drop_cnt_reg;
    assign Irq_O      = !empty || overflow_reg;

endmodule

// File: tb/tb_miner_result_fifo.sv
module tb_miner_result_fifo;

`ifdef MINER_RESULT_TIMESTAMP_EN
    localparam int EW = 16;
`else
    localparam int EW = 15;
`endif
    localparam int DEPTH = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              Clear_I = 1'b0;
    logic              VldNonce_I = 1'b0;
    logic [5:0][31:0]  Nonce_I = '0;
    logic [7:0][31:0]  Hash_I = '0;
    logic [31:0]       HashCounter_I = '0;
    logic              RdReq_I = 1'b0;
    logic [31:0]       RdData_O;
    logic              RdVld_O;
    logic [3:0]        WordIdx_O;
    logic [2:0]        Count_O;
    logic              Empty_O;
    logic              Full_O;
    logic              Overflow_O;
    logic [7:0]        DropCnt_O;
    logic              Irq_O;

    miner_result_fifo #(
        .DEPTH(4), .PTR_WIDTH(2), .NONCE_WORDS(6), .HASH_WORDS(8)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Clear_I(Clear_I), .VldNonce_I(VldNonce_I),
        .Nonce_I(Nonce_I), .Hash_I(Hash_I), .HashCounter_I(HashCounter_I),
        .RdReq_I(RdReq_I), .RdData_O(RdData_O), .RdVld_O(RdVld_O),
        .WordIdx_O(WordIdx_O), .Count_O(Count_O), .Empty_O(Empty_O),
        .Full_O(Full_O), .Overflow_O(Overflow_O), .DropCnt_O(DropCnt_O),
        .Irq_O(Irq_O)
    );

    always #5 Clk = ~Clk;

    // Bench-side cycle reference for the timestamp word.
    logic [31:0] tb_ts = '0;
    always @(posedge Clk) tb_ts <= Rst ? 32'd0 : tb_ts + 32'd1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int model_count = 0;
    logic [31:0] sb[$];

    typedef struct {
        logic [31:0] hc;
        logic [31:0] nbase;
        logic [31:0] hbase;
        int          exp_count;
        int          exp_drops;
    } push_vec_t;

    push_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] hc, input logic [31:0] nb, input logic [31:0] hb);
        HashCounter_I = hc;
        for (int k = 0; k < 6; k++) Nonce_I[k] = nb + 32'(k);
        for (int k = 0; k < 8; k++) Hash_I[k] = hb + 32'(k);
    endtask

    task automatic sb_push_entry(input logic [31:0] hc, input logic [31:0] nb, input logic [31:0] hb);
        sb.push_back(hc);
        for (int k = 0; k < 6; k++) sb.push_back(nb + 32'(k));
        for (int k = 0; k < 8; k++) sb.push_back(hb + 32'(k));
`ifdef MINER_RESULT_TIMESTAMP_EN
        sb.push_back(tb_ts);
`endif
    endtask

    // Push one result; the scoreboard only takes it if the model has room.
    task automatic push_res(input logic [31:0] hc, input logic [31:0] nb, input logic [31:0] hb);
        set_data(hc, nb, hb);
        if (model_count < DEPTH) begin
            sb_push_entry(hc, nb, hb);
            model_count++;
        end
        VldNonce_I = 1'b1;
        tick();
        VldNonce_I = 1'b0;
    endtask

    // Read n words, comparing each against the scoreboard.
    task automatic read_words(input int n, output logic [31:0] last);
        logic [31:0] exp;
        last = '0;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL rd_data: got 0x%08h expected nothing (scoreboard empty)", RdData_O);
            end else begin
                exp = sb.pop_front();
                check("rd_data", RdData_O, exp);
            end
            check("rd_vld", 32'(RdVld_O), 32'd1);
            last = RdData_O;
            RdReq_I = 1'b1;
            tick();
            RdReq_I = 1'b0;
        end
    endtask

    task automatic drain_entry(output logic [31:0] last);
        check("word_idx_start", 32'(WordIdx_O), 32'd0);
        read_words(EW, last);
        model_count--;
    endtask

    task automatic flush_model();
        sb.delete();
        model_count = 0;
    endtask

    logic [31:0] last_w;
    logic [31:0] ts_a;
    logic [31:0] ts_b;

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h1100, 32'h1200, 1, 0};
        vecs[1] = '{32'h0000_2000, 32'h2100, 32'h2200, 2, 0};
        vecs[2] = '{32'h0000_3000, 32'h3100, 32'h3200, 3, 0};
        vecs[3] = '{32'h0000_4000, 32'h4100, 32'h4200, 4, 0};
        vecs[4] = '{32'h0000_5000, 32'h5100, 32'h5200, 4, 1};

        // Reset
        tick(); tick();
        Rst = 1'b0;
        tick();
        check("rst_empty", 32'(Empty_O), 32'd1);
        check("rst_count", 32'(Count_O), 32'd0);
        check("rst_rdvld", 32'(RdVld_O), 32'd0);
        check("rst_irq", 32'(Irq_O), 32'd0);
        check("rst_rddata", RdData_O, 32'd0);
        check("rst_dropcnt", 32'(DropCnt_O), 32'd0);
        check("rst_full", 32'(Full_O), 32'd0);
        check("rst_overflow", 32'(Overflow_O), 32'd0);

        // Single push then full drain
        push_res(32'h1234, 32'h100, 32'h200);
        check("single_count", 32'(Count_O), 32'd1);
        check("single_irq", 32'(Irq_O), 32'd1);
        drain_entry(last_w);
        check("single_empty_after", 32'(Empty_O), 32'd1);
        check("single_irq_after", 32'(Irq_O), 32'd0);
        check("single_rddata_after", RdData_O, 32'd0);

        // RdReq while empty is ignored
        RdReq_I = 1'b1; tick(); RdReq_I = 1'b0;
        check("empty_rdreq_idx", 32'(WordIdx_O), 32'd0);
        check("empty_rdreq_count", 32'(Count_O), 32'd0);

        // Table: five pushes, no reads
        for (int i = 0; i < 5; i++) begin
            push_res(vecs[i].hc, vecs[i].nbase, vecs[i].hbase);
            check("tbl_count", 32'(Count_O), 32'(vecs[i].exp_count));
            check("tbl_dropcnt", 32'(DropCnt_O), 32'(vecs[i].exp_drops));
        end
        check("tbl_full", 32'(Full_O), 32'd1);
        check("tbl_overflow", 32'(Overflow_O), 32'd1);
        check("tbl_irq", 32'(Irq_O), 32'd1);
        for (int e = 0; e < 4; e++) drain_entry(last_w);
        check("tbl_empty_after", 32'(Empty_O), 32'd1);
        check("tbl_irq_sticky", 32'(Irq_O), 32'd1);
        Clear_I = 1'b1; tick(); Clear_I = 1'b0;
        check("tbl_clear_overflow", 32'(Overflow_O), 32'd0);
        check("tbl_clear_irq", 32'(Irq_O), 32'd0);

        // Full, pop of last word coincides with push
        for (int i = 0; i < 4; i++) push_res(32'hA000 + 32'(i), 32'hA100 + 32'(i << 4), 32'hA200 + 32'(i << 4));
        read_words(EW - 1, last_w);
        check("simul_idx_last", 32'(WordIdx_O), 32'(EW - 1));
        check("simul_last_word", RdData_O, sb.pop_front());
        set_data(32'hB000, 32'hB100, 32'hB200);
        sb_push_entry(32'hB000, 32'hB100, 32'hB200);
        RdReq_I = 1'b1; VldNonce_I = 1'b1;
        tick();
        RdReq_I = 1'b0; VldNonce_I = 1'b0;
        check("simul_count", 32'(Count_O), 32'd4);
        check("simul_dropcnt", 32'(DropCnt_O), 32'd0);
        check("simul_overflow", 32'(Overflow_O), 32'd0);
        check("simul_idx", 32'(WordIdx_O), 32'd0);
        for (int e = 0; e < 4; e++) drain_entry(last_w);
        check("simul_empty", 32'(Empty_O), 32'd1);

        // Clear mid-entry together with a push
        for (int i = 0; i < 5; i++) push_res(32'hC000 + 32'(i), 32'hC100, 32'hC200);
        read_words(7, last_w);
        check("clr_idx7", 32'(WordIdx_O), 32'd7);
        check("clr_pre_overflow", 32'(Overflow_O), 32'd1);
        set_data(32'hD000, 32'hD100, 32'hD200);
        Clear_I = 1'b1; VldNonce_I = 1'b1;
        tick();
        Clear_I = 1'b0; VldNonce_I = 1'b0;
        flush_model();
        check("clr_count", 32'(Count_O), 32'd0);
        check("clr_idx", 32'(WordIdx_O), 32'd0);
        check("clr_overflow", 32'(Overflow_O), 32'd0);
        check("clr_dropcnt", 32'(DropCnt_O), 32'd0);
        check("clr_irq", 32'(Irq_O), 32'd0);
        push_res(32'hE000, 32'hE100, 32'hE200);
        drain_entry(last_w);
        check("clr_no_replay_empty", 32'(Empty_O), 32'd1);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) push_res(32'hF000 + 32'(i), 32'hF100, 32'hF200);
        for (int i = 0; i < 300; i++) push_res(32'h9999, 32'h9900, 32'h9A00);
        check("sat_dropcnt", 32'(DropCnt_O), 32'd255);
        check("sat_count", 32'(Count_O), 32'd4);

        // Reset mid-read discards everything
        read_words(3, last_w);
        Rst = 1'b1; tick(); Rst = 1'b0;
        flush_model();
        check("rst_mid_empty", 32'(Empty_O), 32'd1);
        check("rst_mid_idx", 32'(WordIdx_O), 32'd0);
        check("rst_mid_dropcnt", 32'(DropCnt_O), 32'd0);
        push_res(32'h7000, 32'h7100, 32'h7200);
        drain_entry(last_w);

`ifdef MINER_RESULT_TIMESTAMP_EN
        // Two pushes ten cycles apart
        push_res(32'h8000, 32'h8100, 32'h8200);
        for (int i = 0; i < 9; i++) tick();
        push_res(32'h8001, 32'h8101, 32'h8201);
        drain_entry(ts_a);
        drain_entry(ts_b);
        check("ts_delta", ts_b - ts_a, 32'd10);
`else
        ts_a = '0;
        ts_b = '0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
